// File: rtl/kitt_led_driver.sv
`default_nettype none
// ============================================================================
//  Module      : kitt_led_driver
//  Description : Bouncing-head LED scanner with a fading PWM trail.
//                The head LED runs at full brightness. Every other LED keeps
//                a 4-bit level that decays by DECAY per scan step.
//                When ena drops, the whole bar fades out, and the block then
//                returns to IDLE.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   1               system clock
//    rst   in   1               synchronous, active-high reset
//    ena   in   1               debounced scan enable (level)
//    leds  out  N_LEDS          registered PWM drive, 1 = lit
//    pos   out  $clog2(N_LEDS)  registered head index
//    busy  out  1               high while scanning or fading
//  Build option
//    KITT_GAMMA_EN  when defined, levels pass through a perceptual gamma
//                   table before PWM comparison
// ============================================================================
module kitt_led_driver #(
    parameter int N_LEDS      = 8,
    parameter int STEP_CYCLES = 1000000,
    parameter int PWM_DIV     = 16,
    parameter int DECAY       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    output logic [N_LEDS-1:0]         leds,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      busy
);

    localparam int c_POS_W  = $clog2(N_LEDS);
    localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int c_DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [c_POS_W-1:0]  c_POS_LAST = c_POS_W'(N_LEDS - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_END = c_STEP_W'(STEP_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_END  = c_DIV_W'(PWM_DIV - 1);
    localparam logic [3:0]          c_DECAY    = 4'(DECAY);
    localparam logic [3:0]          c_FULL     = 4'hF;
    localparam logic [3:0]          c_PWM_LAST = 4'd14;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FADE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_POS_W-1:0]       r_pos;
    logic [c_POS_W-1:0]       w_pos_nxt;
    logic [c_POS_W-1:0]       w_step_pos;
    logic                     r_dir_left;
    logic                     w_dir_left_nxt;
    logic                     w_step_dir_left;
    logic [N_LEDS-1:0][3:0]   r_level;
    logic [N_LEDS-1:0][3:0]   w_level_base;
    logic [N_LEDS-1:0][3:0]   w_level_nxt;
    logic [N_LEDS-1:0][3:0]   w_duty;
    logic [c_STEP_W-1:0]      r_step_cnt;
    logic [c_STEP_W-1:0]      w_step_cnt_nxt;
    logic                     w_step_tick;
    logic [c_DIV_W-1:0]       r_pwm_div;
    logic [3:0]               r_pwm_cnt;
    logic [N_LEDS-1:0]        r_leds;
    logic                     w_all_zero;

    function automatic logic [3:0] f_decay(input logic [3:0] lvl);
        return (lvl > c_DECAY) ? (lvl - c_DECAY) : 4'd0;
    endfunction

    assign w_step_tick = (r_step_cnt == c_STEP_END);

    always_comb begin
        w_all_zero = 1'b1;
        for (int i = 0; i < N_LEDS; i++) begin
            if (r_level[i] != 4'd0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    // State transition is resolved first; the step tick then acts under
    // the rules of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (ena) w_state_nxt = c_RUN;
            c_RUN:  if (!ena) w_state_nxt = c_FADE;
            c_FADE: begin
                if (ena) begin
                    w_state_nxt = c_RUN;
                end else if (w_all_zero) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Head advance with bounce: the end LED is left on the very next step,
    // so each end is shown for exactly one step.
    always_comb begin
        w_step_pos      = r_pos;
        w_step_dir_left = r_dir_left;
        if (!r_dir_left) begin
            if (r_pos == c_POS_LAST) begin
                w_step_pos      = r_pos - c_POS_W'(1);
                w_step_dir_left = 1'b1;
            end else begin
                w_step_pos = r_pos + c_POS_W'(1);
            end
        end else begin
            if (r_pos == '0) begin
                w_step_pos      = c_POS_W'(1);
                w_step_dir_left = 1'b0;
            end else begin
                w_step_pos = r_pos - c_POS_W'(1);
            end
        end
    end

    always_comb begin
        w_level_base   = r_level;
        w_level_nxt    = r_level;
        w_pos_nxt      = r_pos;
        w_dir_left_nxt = r_dir_left;
        // Entering RUN, from IDLE or FADE, relights the frozen head.
        if ((w_state_nxt == c_RUN) && (r_state != c_RUN)) begin
            w_level_base[r_pos] = c_FULL;
        end
        case (w_state_nxt)
            c_RUN: begin
                w_level_nxt = w_level_base;
                if (w_step_tick) begin
                    for (int i = 0; i < N_LEDS; i++) begin
                        w_level_nxt[i] = f_decay(w_level_base[i]);
                    end
                    w_level_nxt[w_step_pos] = c_FULL;
                    w_pos_nxt               = w_step_pos;
                    w_dir_left_nxt          = w_step_dir_left;
                end
            end
            c_FADE: begin
                if (w_step_tick) begin
                    for (int i = 0; i < N_LEDS; i++) begin
                        w_level_nxt[i] = f_decay(r_level[i]);
                    end
                end
            end
            default: begin
                w_level_nxt    = '0;
                w_pos_nxt      = '0;
                w_dir_left_nxt = 1'b0;
            end
        endcase
    end

    // The prescaler is held at zero in IDLE and restarts when a scan begins.
    // In FADE it keeps counting, so resuming RUN keeps the step cadence.
    always_comb begin
        if ((r_state == c_IDLE) || (w_state_nxt == c_IDLE) || w_step_tick) begin
            w_step_cnt_nxt = '0;
        end else begin
            w_step_cnt_nxt = r_step_cnt + c_STEP_W'(1);
        end
    end

`ifdef KITT_GAMMA_EN
    function automatic logic [3:0] f_gamma(input logic [3:0] lvl);
        logic [3:0] v;
        case (lvl)
            4'd0:    v = 4'd0;
            4'd1:    v = 4'd1;
            4'd2:    v = 4'd1;
            4'd3:    v = 4'd1;
            4'd4:    v = 4'd2;
            4'd5:    v = 4'd2;
            4'd6:    v = 4'd3;
            4'd7:    v = 4'd3;
            4'd8:    v = 4'd4;
            4'd9:    v = 4'd5;
            4'd10:   v = 4'd6;
            4'd11:   v = 4'd7;
            4'd12:   v = 4'd9;
            4'd13:   v = 4'd10;
            4'd14:   v = 4'd12;
            default: v = 4'd15;
        endcase
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            w_duty[i] = f_gamma(r_level[i]);
        end
    end
`else
    assign w_duty = r_level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_pos      <= '0;
            r_dir_left <= 1'b0;
            r_level    <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_dir_left <= w_dir_left_nxt;
            r_level    <= w_level_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    // 15 PWM slots (0..14): level 15 beats every slot and level 0 beats none.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_div <= '0;
            r_pwm_cnt <= 4'd0;
        end else if (r_pwm_div == c_DIV_END) begin
            r_pwm_div <= '0;
            r_pwm_cnt <= (r_pwm_cnt == c_PWM_LAST) ? 4'd0 : (r_pwm_cnt + 4'd1);
        end else begin
            r_pwm_div <= r_pwm_div + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                r_leds[i] <= (w_duty[i] > r_pwm_cnt);
            end
        end
    end

    assign leds = r_leds;
    assign pos  = r_pos;
    assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kitt_led_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kitt_led_driver
//  Description : Self-checking bench for kitt_led_driver. It uses directed
//                vector records, a PWM duty count on a second instance with a
//                long step time, and randomized enable/reset traffic checked
//                cycle by cycle against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kitt_led_driver;

    localparam int N    = 4;
    localparam int STEP = 10;
    localparam int PDIV = 1;
    localparam int DEC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] leds;
    logic [1:0] pos;
    logic       busy;

    logic       rst_p = 1'b1;
    logic       ena_p = 1'b0;
    logic [3:0] leds_p;
    logic [1:0] pos_p;
    logic       busy_p;

    always #5 clk = ~clk;

    kitt_led_driver #(.N_LEDS(N), .STEP_CYCLES(STEP), .PWM_DIV(PDIV), .DECAY(DEC)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .leds(leds), .pos(pos), .busy(busy)
    );

    kitt_led_driver #(.N_LEDS(N), .STEP_CYCLES(64), .PWM_DIV(PDIV), .DECAY(DEC)) u_dut_pwm (
        .clk(clk), .rst(rst_p), .ena(ena_p), .leds(leds_p), .pos(pos_p), .busy(busy_p)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

`ifdef KITT_GAMMA_EN
    int c_gamma [16] = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 9, 10, 12, 15};
    function automatic int duty_of(input int l);
        return c_gamma[l];
    endfunction
`else
    function automatic int duty_of(input int l);
        return l;
    endfunction
`endif

    function automatic int dec(input int l);
        return (l > DEC) ? l - DEC : 0;
    endfunction

    // Reference model: mode 0 idle, 1 run, 2 fade; direction is +1 or -1.
    int         m_mode = 0;
    int         m_pos  = 0;
    int         m_dir  = 1;
    int         m_tick_cnt = 0;
    int         m_pwm  = 0;
    int         m_div  = 0;
    int         m_lvl [N];
    logic [3:0] m_leds = 4'd0;

    task automatic model_step(input logic r, input logic e);
        int nm;
        int np;
        bit tick;
        bit all0;
        if (r) begin
            m_mode = 0; m_pos = 0; m_dir = 1; m_tick_cnt = 0;
            m_pwm = 0; m_div = 0; m_leds = 4'd0;
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) m_leds[i] = (duty_of(m_lvl[i]) > m_pwm);
        tick = (m_tick_cnt == STEP - 1);
        m_div++;
        if (m_div == PDIV) begin
            m_div = 0;
            m_pwm = (m_pwm + 1) % 15;
        end
        all0 = 1;
        for (int i = 0; i < N; i++) if (m_lvl[i] != 0) all0 = 0;
        case (m_mode)
            0:       nm = e ? 1 : 0;
            1:       nm = e ? 1 : 2;
            default: nm = e ? 1 : (all0 ? 0 : 2);
        endcase
        if (nm == 0) begin
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
            m_pos = 0; m_dir = 1; m_tick_cnt = 0;
        end else begin
            if (m_mode == 0) m_tick_cnt = 0;
            else m_tick_cnt = tick ? 0 : m_tick_cnt + 1;
            if (nm == 1 && m_mode != 1) m_lvl[m_pos] = 15;
            if (nm == 1 && tick) begin
                np = m_pos + m_dir;
                if (np < 0 || np >= N) begin
                    m_dir = -m_dir;
                    np = m_pos + m_dir;
                end
                for (int i = 0; i < N; i++) if (i != np) m_lvl[i] = dec(m_lvl[i]);
                m_lvl[np] = 15;
                m_pos = np;
            end
            if (nm == 2 && tick) begin
                for (int i = 0; i < N; i++) m_lvl[i] = dec(m_lvl[i]);
            end
        end
        m_mode = nm;
    endtask

    // One clock: advance the model with the inputs seen at the edge,
    // then compare the main DUT against it.
    task automatic cycle();
        @(posedge clk);
        model_step(rst, ena);
        #1;
        check("model_leds", leds, m_leds);
        check("model_pos", pos, m_pos);
        check("model_busy", busy, (m_mode != 0));
    endtask

    typedef struct {
        logic       r;
        logic       e;
        int         n;
        int         epos;
        logic       ebusy;
        logic [3:0] emask;
        logic [3:0] eleds;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input int n, input int p, input logic b,
                       input logic [3:0] m, input logic [3:0] l, input string nm);
        vec_t v;
        v.r = r; v.e = e; v.n = n; v.epos = p; v.ebusy = b;
        v.emask = m; v.eleds = l; v.name = nm;
        vq.push_back(v);
    endtask

    initial begin
        int  cnt [N];
        bit  found;
        int  len;

        // rst, ena, cycles, pos, busy, leds mask, leds value, name
        add(1, 1,  2, 0, 0, 4'hF, 4'h0, "reset");
        add(0, 1,  1, 0, 1, 4'hF, 4'h0, "run_entry");
        add(0, 1,  1, 0, 1, 4'hF, 4'h1, "head_lit");
        add(0, 1,  8, 0, 1, 4'hF, 4'h1, "pre_step");
        add(0, 1,  1, 1, 1, 4'hF, 4'h1, "step1");
        add(0, 1,  1, 1, 1, 4'hE, 4'h2, "step1_led");
        add(0, 1,  9, 2, 1, 4'hE, 4'h2, "step2");
        add(0, 1, 10, 3, 1, 4'hC, 4'h4, "step3");
        add(0, 1, 10, 2, 1, 4'h8, 4'h8, "step4_bounce");
        add(0, 1, 10, 1, 1, 4'h5, 4'h4, "step5");
        add(0, 1, 10, 0, 1, 4'h3, 4'h2, "step6");
        add(0, 1, 10, 1, 1, 4'h1, 4'h1, "step7_bounce");
        add(0, 1, 10, 2, 1, 4'hA, 4'h2, "step8");
        add(0, 0,  1, 2, 1, 4'hC, 4'h4, "fade_entry");
        add(0, 0,  8, 2, 1, 4'hC, 4'h4, "fade_hold");
        add(0, 0,  1, 2, 1, 4'hC, 4'h4, "fade_tick1");
        add(0, 0, 30, 2, 1, 4'hB, 4'h0, "fade_last");
        add(0, 0,  1, 0, 0, 4'hF, 4'h0, "fade_idle");
        add(0, 0,  3, 0, 0, 4'hF, 4'h0, "idle_hold");
        add(0, 1,  1, 0, 1, 4'hF, 4'h0, "rerun_entry");
        add(0, 1, 40, 2, 1, 4'h8, 4'h8, "rerun_pos2_left");
        add(0, 0,  1, 2, 1, 4'h5, 4'h4, "fade2_entry");
        add(0, 0, 10, 2, 1, 4'h3, 4'h0, "fade2_tick");
        add(0, 1,  1, 2, 1, 4'h3, 4'h0, "resume_edge");
        add(0, 1,  1, 2, 1, 4'h7, 4'h4, "resume_head");
        add(0, 1,  7, 1, 1, 4'h7, 4'h4, "resume_step");
        add(1, 1,  1, 0, 0, 4'hF, 4'h0, "rst_mid_run");
        add(0, 1,  1, 0, 1, 4'hF, 4'h0, "rst_release_run");

        // PWM duty on the long-step instance while the main DUT sits in reset.
        rst = 1'b1; ena = 1'b1;
        rst_p = 1'b1; ena_p = 1'b0;
        repeat (2) cycle();
        rst_p = 1'b0; ena_p = 1'b1;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            cycle();
            if (pos_p == 2'd2) found = 1;
        end
        check("pwm_reach_pos2", found, 1);
        cycle();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int j = 0; j < 15; j++) begin
            for (int i = 0; i < N; i++) cnt[i] += int'(leds_p[i]);
            cycle();
        end
        check("pwm_level15", cnt[2], duty_of(15));
        check("pwm_level11", cnt[1], duty_of(11));
        check("pwm_level7", cnt[0], duty_of(7));
        check("pwm_level0", cnt[3], 0);
        check("pwm_busy", busy_p, 1);

        // Directed vector records.
        for (int k = 0; k < vq.size(); k++) begin
            rst = vq[k].r;
            ena = vq[k].e;
            repeat (vq[k].n) cycle();
            check({vq[k].name, "_pos"}, pos, vq[k].epos);
            check({vq[k].name, "_busy"}, busy, vq[k].ebusy);
            check({vq[k].name, "_leds"}, leds & vq[k].emask, vq[k].eleds);
        end

        // Randomized enable and reset traffic against the model.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(19, 0) == 0) begin
                rst = 1'b1;
                len = $urandom_range(2, 1);
            end else begin
                rst = 1'b0;
                ena = ($urandom_range(3, 0) != 0);
                len = $urandom_range(60, 1);
            end
            repeat (len) cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
